// File: rtl/pr_bus_arbiter.sv
// pr_bus_arbiter: shares the 0x7F00-0x7F43 peripheral bus between M0 (CPU) and M1 (DMA/debug),
// with per-region wait states. Optional macro ARB_FIXED_PRIO_EN makes M0 win every simultaneous request.
module pr_bus_arbiter #(
    parameter logic [3:0] WAIT_UART = 4'd2,
    parameter logic [3:0] WAIT_DEF  = 4'd0
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        m0_req,
    input  logic        m0_we,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wd,
    output logic        m0_ack,
    output logic        m0_err,
    input  logic        m1_req,
    input  logic        m1_we,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wd,
    output logic        m1_ack,
    output logic        m1_err,
    output logic [31:0] rd,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wd,
    input  logic [31:0] bus_rd,
    output logic        busy
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_DONE   = 2'd2;

    function automatic logic addr_mapped(input logic [31:0] a);
        addr_mapped = (a >= 32'h0000_7F00) && (a <= 32'h0000_7F43);
    endfunction

    function automatic logic addr_uart(input logic [31:0] a);
        addr_uart = (a >= 32'h0000_7F10) && (a <= 32'h0000_7F2B);
    endfunction

    // Unmapped addresses take no wait states so the error returns as fast as possible.
    function automatic logic [3:0] region_wait(input logic [31:0] a);
        if (!addr_mapped(a)) begin
            region_wait = 4'd0;
        end else if (addr_uart(a)) begin
            region_wait = WAIT_UART;
        end else begin
            region_wait = WAIT_DEF;
        end
    endfunction

    logic [1:0]  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        owner_q, owner_d;
    logic        we_q, we_d;
    logic        map_q, map_d;
    logic [31:0] bus_addr_q, bus_addr_d;
    logic [31:0] bus_wd_q, bus_wd_d;
    logic        bus_we_q, bus_we_d;
    logic [31:0] rd_q, rd_d;
    logic        m0_ack_q, m0_ack_d;
    logic        m1_ack_q, m1_ack_d;
    logic        m0_err_q, m0_err_d;
    logic        m1_err_q, m1_err_d;
    logic        busy_q, busy_d;
`ifndef ARB_FIXED_PRIO_EN
    logic        rr_ptr_q, rr_ptr_d;
`endif

    logic        grant_s;
    logic        pick_s;
    logic        sel_we_s;
    logic [31:0] sel_addr_s;
    logic [31:0] sel_wd_s;
    logic [3:0]  sel_wait_s;
    logic        sel_map_s;

    // Owner selection among the current requesters.
    always_comb begin
        grant_s = m0_req | m1_req;
        if (m0_req && m1_req) begin
`ifdef ARB_FIXED_PRIO_EN
            pick_s = 1'b0;
`else
            pick_s = rr_ptr_q;
`endif
        end else if (m1_req) begin
            pick_s = 1'b1;
        end else begin
            pick_s = 1'b0;
        end
    end

    assign sel_we_s   = pick_s ? m1_we   : m0_we;
    assign sel_addr_s = pick_s ? m1_addr : m0_addr;
    assign sel_wd_s   = pick_s ? m1_wd   : m0_wd;
    assign sel_wait_s = region_wait(sel_addr_s);
    assign sel_map_s  = addr_mapped(sel_addr_s);

    // Next-state logic; bus_we is precomputed so its register is high only in the last ACCESS cycle.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        owner_d    = owner_q;
        we_d       = we_q;
        map_d      = map_q;
        bus_addr_d = bus_addr_q;
        bus_wd_d   = bus_wd_q;
        bus_we_d   = 1'b0;
        rd_d       = rd_q;
        m0_ack_d   = 1'b0;
        m1_ack_d   = 1'b0;
        m0_err_d   = 1'b0;
        m1_err_d   = 1'b0;
`ifndef ARB_FIXED_PRIO_EN
        rr_ptr_d   = rr_ptr_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (grant_s) begin
                    state_d    = ST_ACCESS;
                    owner_d    = pick_s;
                    we_d       = sel_we_s;
                    map_d      = sel_map_s;
                    bus_addr_d = sel_addr_s;
                    bus_wd_d   = sel_wd_s;
                    cnt_d      = sel_wait_s;
                    bus_we_d   = sel_we_s & sel_map_s & (sel_wait_s == 4'd0);
`ifndef ARB_FIXED_PRIO_EN
                    rr_ptr_d   = ~pick_s;
`endif
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                if (cnt_q != 4'd0) begin
                    cnt_d    = cnt_q - 4'd1;
                    bus_we_d = we_q & map_q & (cnt_q == 4'd1);
                end else begin
                    state_d = ST_DONE;
                    rd_d    = map_q ? bus_rd : 32'hFFFF_FFFF;
                    if (owner_q) begin
                        m1_ack_d = 1'b1;
                        m1_err_d = ~map_q;
                    end else begin
                        m0_ack_d = 1'b1;
                        m0_err_d = ~map_q;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 4'd0;
            owner_q    <= 1'b0;
            we_q       <= 1'b0;
            map_q      <= 1'b0;
            bus_addr_q <= 32'h0000_0000;
            bus_wd_q   <= 32'h0000_0000;
            bus_we_q   <= 1'b0;
            rd_q       <= 32'h0000_0000;
            m0_ack_q   <= 1'b0;
            m1_ack_q   <= 1'b0;
            m0_err_q   <= 1'b0;
            m1_err_q   <= 1'b0;
            busy_q     <= 1'b0;
`ifndef ARB_FIXED_PRIO_EN
            rr_ptr_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            owner_q    <= owner_d;
            we_q       <= we_d;
            map_q      <= map_d;
            bus_addr_q <= bus_addr_d;
            bus_wd_q   <= bus_wd_d;
            bus_we_q   <= bus_we_d;
            rd_q       <= rd_d;
            m0_ack_q   <= m0_ack_d;
            m1_ack_q   <= m1_ack_d;
            m0_err_q   <= m0_err_d;
            m1_err_q   <= m1_err_d;
            busy_q     <= busy_d;
`ifndef ARB_FIXED_PRIO_EN
            rr_ptr_q   <= rr_ptr_d;
`endif
        end
    end

    assign m0_ack   = m0_ack_q;
    assign m0_err   = m0_err_q;
    assign m1_ack   = m1_ack_q;
    assign m1_err   = m1_err_q;
    assign rd       = rd_q;
    assign bus_we   = bus_we_q;
    assign bus_addr = bus_addr_q;
    assign bus_wd   = bus_wd_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_pr_bus_arbiter.sv
// Self-checking bench for pr_bus_arbiter: vector table plus hand-written reset, round-robin
// and dropped-request sequences, with expected results queued when stimulus is driven.
module tb_pr_bus_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        m0_req, m0_we, m1_req, m1_we;
    logic [31:0] m0_addr, m0_wd, m1_addr, m1_wd;
    logic        m0_ack, m0_err, m1_ack, m1_err;
    logic [31:0] rd, bus_addr, bus_wd, bus_rd;
    logic        bus_we, busy;
    logic [31:0] brd_v;

    int n_total = 0;
    int n_pass  = 0;

    int          we_cnt = 0;
    logic [31:0] we_addr = 32'h0;
    logic [31:0] we_wd   = 32'h0;

    always #5 clk = ~clk;

    assign bus_rd = brd_v;

    pr_bus_arbiter dut (
        .clk(clk), .reset_n(reset_n),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wd(m0_wd),
        .m0_ack(m0_ack), .m0_err(m0_err),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wd(m1_wd),
        .m1_ack(m1_ack), .m1_err(m1_err),
        .rd(rd), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wd(bus_wd),
        .bus_rd(bus_rd), .busy(busy)
    );

    // Write-strobe monitor: counts bus_we cycles and records what was written.
    always @(posedge clk) begin
        if (bus_we) begin
            we_cnt  <= we_cnt + 1;
            we_addr <= bus_addr;
            we_wd   <= bus_wd;
        end
    end

    typedef struct {
        logic        m;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] brd;
        logic        err;
        logic [31:0] rd;
        int          lat;
        int          pulses;
        logic        drop;
    } vec_t;

    typedef struct {
        logic        m;
        logic        err;
        logic [31:0] rd;
        int          lat;
        int          pulses;
        logic [31:0] addr;
        logic [31:0] wd;
    } exp_t;

    exp_t sb[$];
    logic rr_q[$];
    vec_t vecs [0:10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_m0_ack"}, {31'd0, m0_ack}, 32'd0);
        chk({tag, "_m1_ack"}, {31'd0, m1_ack}, 32'd0);
        chk({tag, "_m0_err"}, {31'd0, m0_err}, 32'd0);
        chk({tag, "_m1_err"}, {31'd0, m1_err}, 32'd0);
        chk({tag, "_bus_we"}, {31'd0, bus_we}, 32'd0);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_rd"}, rd, 32'd0);
        chk({tag, "_bus_addr"}, bus_addr, 32'd0);
        chk({tag, "_bus_wd"}, bus_wd, 32'd0);
    endtask

    task automatic run_vec(input vec_t v);
        exp_t e;
        exp_t x;
        int   lat;
        bit   got;
        int   p0;
        e = '{v.m, v.err, v.rd, v.lat, v.pulses, v.addr, v.wd};
        sb.push_back(e);
        @(negedge clk);
        brd_v = v.brd;
        p0 = we_cnt;
        if (v.m) begin
            m1_req = 1'b1; m1_we = v.we; m1_addr = v.addr; m1_wd = v.wd;
        end else begin
            m0_req = 1'b1; m0_we = v.we; m0_addr = v.addr; m0_wd = v.wd;
        end
        lat = 0;
        got = 1'b0;
        while (!got && lat < 40) begin
            @(negedge clk);
            lat++;
            if (v.drop && lat == 1) begin
                m0_req = 1'b0;
                m1_req = 1'b0;
            end
            if (m0_ack || m1_ack) got = 1'b1;
        end
        m0_req = 1'b0;
        m1_req = 1'b0;
        x = sb.pop_front();
        chk("ack_seen", {31'd0, got}, 32'd1);
        if (got) begin
            chk("ack_m0", {31'd0, m0_ack}, {31'd0, ~x.m});
            chk("ack_m1", {31'd0, m1_ack}, {31'd0, x.m});
            chk("err", {31'd0, (x.m ? m1_err : m0_err)}, {31'd0, x.err});
            chk("other_err", {31'd0, (x.m ? m0_err : m1_err)}, 32'd0);
            chk("rd", rd, x.rd);
            chk("latency", lat, x.lat);
            @(negedge clk);
            chk("ack_width", {30'd0, m0_ack, m1_ack}, 32'd0);
            chk("idle_busy", {31'd0, busy}, 32'd0);
            chk("rd_held", rd, x.rd);
            chk("we_pulses", we_cnt - p0, x.pulses);
            if (x.pulses > 0) begin
                chk("we_addr", we_addr, x.addr);
                chk("we_wd", we_wd, x.wd);
            end
        end
    endtask

    initial begin
        int  n;
        int  cyc;
        int  p0;
        bit  saw;
        logic exp_m;

        //         m     we    addr           wd             brd            err   rd             lat pulses drop
        vecs[0]  = '{1'b0, 1'b1, 32'h0000_7F34, 32'h0000_00A5, 32'h0BAD_F00D, 1'b0, 32'h0BAD_F00D, 2, 1, 1'b0};
        vecs[1]  = '{1'b1, 1'b0, 32'h0000_7F10, 32'h0000_0000, 32'h1234_5678, 1'b0, 32'h1234_5678, 4, 0, 1'b0};
        vecs[2]  = '{1'b0, 1'b1, 32'h0000_7F50, 32'h0000_1111, 32'hCAFE_0000, 1'b1, 32'hFFFF_FFFF, 2, 0, 1'b0};
        vecs[3]  = '{1'b1, 1'b1, 32'h0000_7F2B, 32'h0000_0055, 32'h0000_0000, 1'b0, 32'h0000_0000, 4, 1, 1'b0};
        vecs[4]  = '{1'b0, 1'b0, 32'h0000_7F2C, 32'h0000_0000, 32'hA0A0_A0A0, 1'b0, 32'hA0A0_A0A0, 2, 0, 1'b0};
        vecs[5]  = '{1'b1, 1'b0, 32'h0000_7F43, 32'h0000_0000, 32'h4343_4343, 1'b0, 32'h4343_4343, 2, 0, 1'b0};
        vecs[6]  = '{1'b0, 1'b0, 32'h0000_7F44, 32'h0000_0000, 32'h4444_4444, 1'b1, 32'hFFFF_FFFF, 2, 0, 1'b0};
        vecs[7]  = '{1'b1, 1'b0, 32'h0000_7EFF, 32'h0000_0000, 32'hEEEE_EEEE, 1'b1, 32'hFFFF_FFFF, 2, 0, 1'b0};
        vecs[8]  = '{1'b0, 1'b0, 32'h0000_7F0F, 32'h0000_0000, 32'h0F0F_0F0F, 1'b0, 32'h0F0F_0F0F, 2, 0, 1'b0};
        vecs[9]  = '{1'b1, 1'b1, 32'h0001_7F10, 32'h0000_0009, 32'h1111_1111, 1'b1, 32'hFFFF_FFFF, 2, 0, 1'b0};
        vecs[10] = '{1'b0, 1'b1, 32'h0000_7F14, 32'h0000_003C, 32'h5A5A_5A5A, 1'b0, 32'h5A5A_5A5A, 4, 1, 1'b1};

        reset_n = 1'b0;
        brd_v   = 32'h7777_0000;
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h0000_7F00; m0_wd = 32'h0;
        m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h0000_7F04; m1_wd = 32'h0;

        #12;
        chk_idle_outputs("reset");

        // Both masters request continuously from reset.
        for (int i = 0; i < 6; i++) begin
`ifdef ARB_FIXED_PRIO_EN
            rr_q.push_back(1'b0);
`else
            rr_q.push_back(i[0]);
`endif
        end
        @(negedge clk);
        reset_n = 1'b1;
        n = 0;
        cyc = 0;
        while (n < 6 && cyc < 80) begin
            @(negedge clk);
            cyc++;
            if (m0_ack || m1_ack) begin
                exp_m = rr_q.pop_front();
                chk("ack_overlap", {31'd0, m0_ack & m1_ack}, 32'd0);
                chk("rr_owner", {31'd0, m1_ack}, {31'd0, exp_m});
                chk("rr_rd", rd, 32'h7777_0000);
                n++;
            end
        end
        chk("rr_count", n, 6);
        m0_req = 1'b0;
        m1_req = 1'b0;
        repeat (6) @(negedge clk);

        for (int i = 0; i <= 10; i++) begin
            run_vec(vecs[i]);
        end

        // Reset asserted while a UART write is still waiting.
        @(negedge clk);
        brd_v = 32'h9999_9999;
        p0 = we_cnt;
        m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'h0000_7F10; m1_wd = 32'h0000_0077;
        @(negedge clk);
        chk("mid_busy", {31'd0, busy}, 32'd1);
        chk("mid_bus_addr", bus_addr, 32'h0000_7F10);
        #2 reset_n = 1'b0;
        #1;
        chk_idle_outputs("midreset");
        m1_req = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        saw = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (m0_ack || m1_ack || busy) saw = 1'b1;
        end
        chk("no_ack_after_reset", {31'd0, saw}, 32'd0);
        chk("reset_no_write", we_cnt - p0, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
